// File: rtl/triangle_monitor.sv
// triangle_monitor
// Receiver/checker for an N-bit triangle sample stream (0 .. MAX .. 0 ...).
// Locks at a valley (sample 0), then tracks the +1/-1 slope. It reports
// direction, peak/valley events and the valley-to-valley period in accepted
// samples, and counts any step that breaks the ideal pattern.
module triangle_monitor #(
   parameter int N        = 8,
   parameter int PERIOD_W = N + 1,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [N-1:0]        in,
   output logic                locked,
   output logic                dir,
   output logic                peak,
   output logic                valley,
   output logic                period_valid,
   output logic [PERIOD_W-1:0] period,
   output logic                err,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RISING  = 2'd1,
      FALLING = 2'd2
   } state_t;

   localparam logic [N-1:0] MAX = '1;

   state_t              r_state;
   logic [N-1:0]        r_prev;
   logic [PERIOD_W-1:0] r_cnt;
   logic                r_locked;
   logic                r_dir;
   logic                r_peak;
   logic                r_valley;
   logic                r_period_valid;
   logic [PERIOD_W-1:0] r_period;
   logic                r_err;
   logic [ERRCNT_W-1:0] r_err_count;

   // Neighbour values are formed one bit wider than the sample so that
   // MAX+1 and 0-1 can never compare equal to a legal N-bit input.
   logic [N:0]          w_in_ext;
   logic [N:0]          w_prev_inc;
   logic [N:0]          w_prev_dec;
   logic [PERIOD_W-1:0] w_cnt_inc;
   logic [ERRCNT_W-1:0] w_err_inc;

   assign w_in_ext   = {1'b0, in};
   assign w_prev_inc = {1'b0, r_prev} + 1'b1;
   assign w_prev_dec = {1'b0, r_prev} - 1'b1;
   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_err_inc  = (r_err_count == '1) ? r_err_count : r_err_count + 1'b1;

   // Tracking state machine with all outputs registered; pulses clear every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_prev         <= '0;
         r_cnt          <= '0;
         r_locked       <= 1'b0;
         r_dir          <= 1'b0;
         r_peak         <= 1'b0;
         r_valley       <= 1'b0;
         r_period_valid <= 1'b0;
         r_period       <= '0;
         r_err          <= 1'b0;
         r_err_count    <= '0;
      end else begin
         r_peak         <= 1'b0;
         r_valley       <= 1'b0;
         r_period_valid <= 1'b0;
         r_err          <= 1'b0;
         if (ena) begin
            r_prev <= in;
            case (r_state)
               IDLE: begin
                  // Only a valley can start tracking; nothing is an error here.
                  if (in == '0) begin
                     r_state  <= RISING;
                     r_cnt    <= '0;
                     r_locked <= 1'b1;
                     r_dir    <= 1'b1;
                  end
               end
               RISING: begin
                  if (w_in_ext == w_prev_inc) begin
                     r_cnt <= w_cnt_inc;
                     if (in == MAX) begin
                        r_peak  <= 1'b1;
                        r_state <= FALLING;
                        r_dir   <= 1'b0;
                     end
                  end else begin
                     // Bad step: drop lock; even a 0 here must wait for the next sample.
                     r_err       <= 1'b1;
                     r_err_count <= w_err_inc;
                     r_state     <= IDLE;
                     r_cnt       <= '0;
                     r_locked    <= 1'b0;
                     r_dir       <= 1'b0;
                  end
               end
               FALLING: begin
                  if (w_in_ext == w_prev_dec) begin
                     if (in == '0) begin
                        r_valley       <= 1'b1;
                        r_period_valid <= 1'b1;
                        r_period       <= w_cnt_inc;
                        r_cnt          <= '0;
                        r_state        <= RISING;
                        r_dir          <= 1'b1;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_err       <= 1'b1;
                     r_err_count <= w_err_inc;
                     r_state     <= IDLE;
                     r_cnt       <= '0;
                     r_locked    <= 1'b0;
                     r_dir       <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= IDLE;
                  r_cnt    <= '0;
                  r_locked <= 1'b0;
                  r_dir    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked       = r_locked;
   assign dir          = r_dir;
   assign peak         = r_peak;
   assign valley       = r_valley;
   assign period_valid = r_period_valid;
   assign period       = r_period;
   assign err          = r_err;
   assign err_count    = r_err_count;

endmodule
